// File: rtl/fifo_ctrl.sv
// First-word-fall-through pointer/status controller in front of a 3-port RAM; push-to-head latency 1 cycle, we is combinational.
// No backpressure: a push while full (without pop) or a pop while empty is dropped and latched in a sticky error flag.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] tail_q, tail_d, head_q, head_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  logic af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic push_ok, pop_ok;

  always_comb begin
    // A push into a full FIFO is legal when the same cycle frees the head slot.
    push_ok = wr & (~full_q | rd);
    pop_ok  = rd & ~empty_q;

    tail_d  = push_ok ? tail_q + ADDR_WIDTH'(1) : tail_q;
    head_d  = pop_ok  ? head_q + ADDR_WIDTH'(1) : head_q;

    count_d = count_q;
    if (push_ok & ~pop_ok)
      count_d = count_q + (ADDR_WIDTH+1)'(1);
    else if (pop_ok & ~push_ok)
      count_d = count_q - (ADDR_WIDTH+1)'(1);

    // Status comes from the next count so it lines up with count every cycle.
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);

    // Setting an error has priority over clearing it.
    ovf_d   = (wr & full_q & ~rd) | (ovf_q & ~clr_err);
    unf_d   = (rd & empty_q)      | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tail_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tail_q  <= tail_d;
      head_q  <= head_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign we           = push_ok & reset_n;
  assign w_addr       = tail_q;
  assign r_addr       = head_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural RAM; expected values are hand-computed for D = 8.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr, rd, clr_err;
  logic [7:0] w_data;
  logic       we;
  logic [2:0] w_addr, r_addr;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [7:0] mem [8];
  logic [7:0] head;
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .clr_err(clr_err),
    .we(we), .w_addr(w_addr), .r_addr(r_addr), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always @(posedge clk) if (we) mem[w_addr] <= w_data;
  assign head = mem[r_addr];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; clr_err = c; w_data = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    reset_n = 1'b0; wr = 0; rd = 0; clr_err = 0; w_data = 0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_addr", {r_addr, w_addr}, 0);
    chk("rst_err", {overflow, underflow}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // fill to full
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 8'(8'h10 + i));
      chk("fill_we", we, 1);
      tick;
      chk("fill_count", count, i + 1);
      chk("fill_full", full, (i == 7) ? 1 : 0);
      chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
      chk("fill_empty", empty, 0);
      if (i == 0) chk("fill_head0", head, 8'h10);
    end
    drive(1, 0, 0, 8'hEE);
    chk("ovf_we", we, 0);
    tick;
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_waddr", w_addr, 0);

    // clear coinciding with a fresh overflow: set wins
    drive(1, 0, 1, 8'hEE);
    chk("clrset_we", we, 0);
    tick;
    chk("clrset_ovf", overflow, 1);

    // drain
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 8'h00);
      chk("drain_head", head, 8'h10 + i);
      tick;
      chk("drain_count", count, 7 - i);
      chk("drain_empty", empty, (i == 7) ? 1 : 0);
      chk("drain_ae", almost_empty, (7 - i <= 2) ? 1 : 0);
    end
    chk("drain_raddr", r_addr, 0);
    drive(0, 1, 0, 8'h00);
    tick;
    chk("unf_flag", underflow, 1);
    chk("unf_raddr", r_addr, 0);
    chk("unf_count", count, 0);

    // simultaneous wr & rd while empty
    drive(1, 1, 0, 8'hA5);
    chk("sim_empty_we", we, 1);
    tick;
    chk("sim_empty_count", count, 1);
    chk("sim_empty_unf", underflow, 1);
    chk("sim_empty_empty", empty, 0);
    chk("sim_empty_head", head, 8'hA5);
    chk("sim_empty_addr", {r_addr, w_addr}, {3'd0, 3'd1});

    // clear both sticky flags
    drive(0, 0, 1, 8'h00);
    tick;
    chk("clr_both", {overflow, underflow}, 0);

    // refill, then simultaneous wr & rd while full
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 8'(8'h20 + i));
      tick;
    end
    chk("refill_full", full, 1);
    chk("refill_waddr", w_addr, 0);
    drive(1, 1, 0, 8'h27);
    chk("sim_full_we", we, 1);
    chk("sim_full_head", head, 8'hA5);
    tick;
    chk("sim_full_count", count, 8);
    chk("sim_full_ovf", overflow, 0);
    chk("sim_full_full", full, 1);
    chk("sim_full_addr", {r_addr, w_addr}, {3'd1, 3'd1});

    // pop down to 3
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 8'h00);
      chk("pop5_head", head, 8'h20 + i);
      tick;
    end
    chk("pop5_count", count, 3);
    chk("pop5_raddr", r_addr, 6);

    // wrap-around with count held at 3
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 0, 8'(8'h40 + k));
      chk("wrap_head", head, (k < 3) ? (8'h25 + k) : (8'h40 + k - 3));
      tick;
      chk("wrap_count", count, 3);
      chk("wrap_raddr", r_addr, (7 + k) % 8);
      chk("wrap_waddr", w_addr, (2 + k) % 8);
    end
    chk("wrap_err", {overflow, underflow}, 0);

    // asynchronous reset mid-burst
    drive(1, 0, 0, 8'h99);
    reset_n = 1'b0;
    #1;
    chk("mrst_we", we, 0);
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_ae", almost_empty, 1);
    chk("mrst_full", {full, almost_full}, 0);
    chk("mrst_addr", {r_addr, w_addr}, 0);
    chk("mrst_err", {overflow, underflow}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller that turns the three-port RAM into a first-word-fall-through FIFO. It sits directly in front of the RAM: it drives the RAM's write enable, write address and asynchronous read address, and the RAM's asynchronous read data is the FIFO head. The block also provides occupancy, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.

## Interface
- ADDR_WIDTH, 3, RAM address width; depth D = 2**ADDR_WIDTH
- AF_LEVEL, 2**ADDR_WIDTH - 2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr  in  1  push request; data is presented directly to the RAM w_data
- rd  in  1  pop request; consumes the current head word
- clr_err  in  1  synchronous clear of the overflow and underflow flags
- we  out  1  RAM write enable; combinational, = accepted push
- w_addr  out  ADDR_WIDTH  RAM write address (tail)
- r_addr  out  ADDR_WIDTH  RAM async read address (head)
- count  out  ADDR_WIDTH+1  occupancy, 0..D
- full, empty  out  1  count == D / count == 0
- almost_full, almost_empty  out  1  threshold flags, registered
- overflow, underflow  out  1  sticky error flags

## Operation
- State: tail pointer, head pointer, count (ADDR_WIDTH+1 bits), flag registers, error registers. All outputs except we are registered.
- push_ok = wr & (~full | rd). pop_ok = rd & ~empty.
- we = push_ok. This is the only combinational output and does not depend on clr_err.
- On push_ok, the tail advances by 1 and wraps modulo D.
- On pop_ok, the head advances by 1 and wraps modulo D.
- Count update:
  - +1 if push_ok & ~pop_ok
  - −1 if pop_ok & ~push_ok
  - unchanged otherwise
- Simultaneous events:
  - Full with wr & rd: both are performed. The write lands on the slot being vacated. count stays D. No overflow.
  - Empty with wr & rd: the push is performed and the pop is ignored. count becomes 1. underflow is set.
  - Non-empty, non-full with wr & rd: both are performed and count is unchanged.
- Errors:
  - overflow is set on wr & full & ~rd; the push is dropped and no state changes.
  - underflow is set on rd & empty; the pop is dropped.
  - Both flags are sticky until clr_err. If clr_err and a new error occur in the same cycle, set wins.
- Flags are recomputed from next-count every cycle, so they agree with count in the same cycle.
- Parameter legality: 0 <= AE_LEVEL < AF_LEVEL <= D. Other values are unsupported.

## Timing
- Reset (reset_n low, asynchronous) forces:
  - head = tail = 0, so r_addr = w_addr = 0
  - count = 0
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - overflow = underflow = 0
- we is gated low while reset_n is low.
- Reset asserted mid-operation discards all contents immediately. There is no drain.
- Write latency: the RAM captures the word at the edge where we = 1. From the next cycle it is visible at the head if the FIFO was empty. Push-to-head latency is 1 cycle and empty deasserts on that same edge.
- Read: the head word is valid combinationally whenever empty = 0. rd at edge N advances r_addr, and the next word is on the RAM output after edge N.
- Full/empty deassert on the edge that changes count. There is no extra latency.
- Wrap-around: pointers go from D−1 to 0 with no bubble. Full and empty are derived from count, never from pointer equality.

## Test plan
- Reset then idle:
  - After reset_n = 0 mid-burst, check count = 0, empty = 1, almost_empty = 1, r_addr = w_addr = 0, overflow = underflow = 0.
- Fill to full with D = 8:
  - Push 0x10..0x17. full asserts on the 8th edge, almost_full asserts when count = 6, and we = 1 on each push.
  - A 9th wr alone gives we = 0, count stays 8, overflow = 1.
- Drain:
  - Pop 8 times; the head reads 0x10..0x17 in order.
  - empty asserts after the 8th pop and almost_empty asserts at count = 2.
  - An extra rd sets underflow and leaves r_addr unchanged.
- Simultaneous wr & rd:
  - At full: count stays 8, both pointers advance, no overflow.
  - At empty: count becomes 1, head = pushed word next cycle, underflow = 1.
- Wrap-around:
  - Run 20 interleaved push/pop pairs with count held at 3.
  - Pointers wrap from 7 to 0 and data order is preserved.
- Error clear:
  - With overflow = 1, assert clr_err for 1 cycle; both flags clear.
  - Assert clr_err together with wr & full & ~rd; overflow stays 1.
